prince_round_ctrl: RTL and testbench
====================================

Name: prince_round_ctrl

Overview:
- Sequencing FSM for the two-share, round-based PRINCE datapath.
- Accepts a start request and latches encrypt/decrypt mode.
- Drives the round-counter controls and the four datapath mux selects for all 12 masked S-box passes.
- Raises a one-cycle done strobe when both output shares are valid.
- Sits between the requester (top-level wrapper / bus interface) and the datapath; owns no data.

Parameters:
- SB_LAT, 2, register stages inside one masked S-box; cycles per pass (legal 1..7).
- N_PASS, 12, S-box passes per block (5 forward + middle S + middle S^-1 + 5 inverse); fixed by PRINCE, not for override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- dec_in  in  1  mode sampled with start (1 = decrypt, 0 = encrypt)
- ready  out  1  controller idle, start may be accepted
- busy  out  1  encryption/decryption in progress
- done  out  1  one-cycle strobe, out_share0/out_share1 valid this cycle
- Dec_EncBar  out  1  latched mode, held stable from accept until next accept
- cnt_rst  out  1  synchronous reset of the datapath 4-bit round counter
- cnt_en  out  1  round counter increment enable
- start_path  out  1  1 = datapath takes input shares, 0 = feedback path
- inv1_ctrl  out  1  pre-S-box mux select (1 = inverse-half SR path)
- inv2_ctrl  out  1  post-S-box mux select (1 = forward-half direct path)
- prng_en  out  1  fresh 288-bit PRNG word required this cycle

Behaviour:
- Reset (rst_n=0, async): state IDLE, sub-cycle counter=0, pass counter=0, Dec_EncBar=0.
  - Outputs: ready=1, cnt_rst=1; busy, done, cnt_en, start_path, inv1_ctrl, inv2_ctrl, prng_en all 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - ready=1, cnt_rst=1.
  - start=1: latch dec_in into Dec_EncBar, clear both counters, go to RUN next edge.
  - start=0: stay.
- RUN:
  - busy=1, prng_en=1, cnt_rst=0.
  - sub counter counts 0..SB_LAT-1; pass counter p counts 0..11.
  - start_path=1 only for p=0.
  - inv2_ctrl=1 for p<=4; 0 for p>=5.
  - inv1_ctrl=1 for p>=6; 0 for p<=5.
  - All selects are registered and constant for every cycle of a pass.
  - cnt_en=1 only on the last sub-cycle of a pass (sub=SB_LAT-1); sub then wraps to 0 and p increments.
  - p=11 with sub=SB_LAT-1: cnt_en=0, go to FIN.
- FIN:
  - One cycle: done=1, busy=0, prng_en=0; selects keep the p=11 values so the datapath outputs stay valid.
  - Next edge: IDLE.
- Latency: accept edge to done = 12*SB_LAT+1 cycles; 25 cycles for SB_LAT=2.
- start while busy or in FIN: ignored, not queued.
- start asserted continuously: a new block is accepted on the first IDLE cycle after FIN.
  - Back-to-back throughput: 12*SB_LAT+2 cycles per block.
- dec_in changes while busy: no effect until next accept.
- round_num seen by the datapath equals p during RUN; it never exceeds 11.
- Reset mid-operation: immediate return to IDLE; no done; round counter cleared via cnt_rst.
- Exactly one of ready, busy, done is high in any cycle.

Optional Feature:
- PRINCE_ABORT_EN: adds input abort (1 bit).
- With the macro defined:
  - abort=1 in RUN or FIN forces IDLE at the next edge; done is suppressed and cnt_rst=1 the following cycle.
  - abort=1 in IDLE wins over start.
- Without the macro: no abort port; a block always runs to completion.

Test Plan:
- Reset release, SB_LAT=2 -> ready=1, cnt_rst=1, all other outputs 0; start=1, dec_in=0 -> Dec_EncBar=0, done exactly 25 cycles after the accept edge.
- Trace during one block -> start_path high cycles 1-2 only; inv2_ctrl high cycles 1-10; inv1_ctrl high cycles 13-24; cnt_en high 11 times at cycles 2,4,...,22.
- Encrypt plaintext 0x0000000000000000 with key 0, masks random; datapath plus controller -> out_share0^out_share1 = 0x818665aa0d02dfda at done.
- Decrypt that ciphertext with dec_in=1 and the same key -> recovered 0x0000000000000000; start pulsed during busy is ignored and gives a single done.
- rst_n dropped at pass 6 -> outputs return to reset values asynchronously; no done; next start runs the full 25-cycle sequence.
- PRINCE_ABORT_EN, abort at pass 3 -> IDLE next cycle, no done; with start held high, the next accept follows after one IDLE cycle.

Source files
------------

// File: rtl/prince_round_ctrl.sv
// Sequencing FSM for the two-share round-based PRINCE datapath.
// Optional abort input enabled by defining PRINCE_ABORT_EN.
module prince_round_ctrl #(
   parameter int unsigned SB_LAT = 2,
   parameter int unsigned N_PASS = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic dec_in,
`ifdef PRINCE_ABORT_EN
   input  logic abort,
`endif
   output logic ready,
   output logic busy,
   output logic done,
   output logic Dec_EncBar,
   output logic cnt_rst,
   output logic cnt_en,
   output logic start_path,
   output logic inv1_ctrl,
   output logic inv2_ctrl,
   output logic prng_en
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam logic [2:0] SUB_LAST = 3'(SB_LAT - 1);
   localparam logic [3:0] P_LAST   = 4'(N_PASS - 1);

   state_e     state_q, state_d;
   logic [2:0] sub_q, sub_d;
   logic [3:0] p_q, p_d;
   logic       dec_q, dec_d;
   logic       abort_w;

`ifdef PRINCE_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign Dec_EncBar = dec_q;

   // State, counters and latched mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sub_q   <= '0;
         p_q     <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         p_q     <= p_d;
         dec_q   <= dec_d;
      end
   end

   // Next-state and output decode; selects follow the registered pass count
   always_comb begin
      state_d    = state_q;
      sub_d      = sub_q;
      p_d        = p_q;
      dec_d      = dec_q;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cnt_rst    = 1'b0;
      cnt_en     = 1'b0;
      start_path = 1'b0;
      inv1_ctrl  = 1'b0;
      inv2_ctrl  = 1'b0;
      prng_en    = 1'b0;
      if (state_q != IDLE) begin
         start_path = (p_q == 4'd0);
         inv2_ctrl  = (p_q <= 4'd4);
         inv1_ctrl  = (p_q >= 4'd6);
      end
      unique case (state_q)
         IDLE: begin
            ready   = 1'b1;
            cnt_rst = 1'b1;
            if (start && !abort_w) begin
               dec_d   = dec_in;
               sub_d   = '0;
               p_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            prng_en = 1'b1;
            if (sub_q == SUB_LAST) begin
               sub_d = '0;
               if (p_q == P_LAST) begin
                  state_d = FIN;
               end else begin
                  cnt_en = 1'b1;
                  p_d    = p_q + 4'd1;
               end
            end else begin
               sub_d = sub_q + 3'd1;
            end
            if (abort_w) state_d = IDLE;
         end
         FIN: begin
            done    = !abort_w;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Self-checking bench for prince_round_ctrl.
// Cycle-count reference model, directed and random stimulus.
module tb_prince_round_ctrl;

   localparam int L   = 2;
   localparam int RUNC = 12 * L;
   localparam int TOT = RUNC + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic dec_in = 1'b0;
   logic ab = 1'b0;
   logic ready, busy, done, Dec_EncBar, cnt_rst, cnt_en;
   logic start_path, inv1_ctrl, inv2_ctrl, prng_en;

   int checks = 0;
   int errors = 0;
   int k = 0;
   bit mode = 1'b0;

   prince_round_ctrl #(.SB_LAT(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dec_in     (dec_in),
`ifdef PRINCE_ABORT_EN
      .abort      (ab),
`endif
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .Dec_EncBar (Dec_EncBar),
      .cnt_rst    (cnt_rst),
      .cnt_en     (cnt_en),
      .start_path (start_path),
      .inv1_ctrl  (inv1_ctrl),
      .inv2_ctrl  (inv2_ctrl),
      .prng_en    (prng_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)",
                  name, act, exp, k, $time);
      end
   endtask

   // k = cycles since accept edge (0 = idle), block is RUNC cycles + 1 done
   task automatic check_all();
      int p;
      bit act, run;
      logic [9:0] e, a;
      act = (k != 0);
      run = (k >= 1 && k <= RUNC);
      p = run ? (k - 1) / L : 11;
      e[9] = (k == 0);
      e[8] = run;
      e[7] = (k == TOT) && !ab;
      e[6] = mode;
      e[5] = (k == 0);
      e[4] = run && (k % L == 0) && (k < RUNC);
      e[3] = act && (p == 0);
      e[2] = act && (p >= 6);
      e[1] = act && (p <= 4);
      e[0] = run;
      a = {ready, busy, done, Dec_EncBar, cnt_rst, cnt_en,
           start_path, inv1_ctrl, inv2_ctrl, prng_en};
      chk("outputs", int'(a), int'(e));
      if (!ab) chk("onehot_rbd", int'($onehot({ready, busy, done})), 1);
   endtask

   task automatic step();
      @(posedge clk);
      if (ab) k = 0;
      else if (k == 0) begin
         if (start) begin
            k = 1;
            mode = dec_in;
         end
      end else if (k == TOT) k = 0;
      else k++;
      #1;
      check_all();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      k = 0;
      mode = 1'b0;
      check_all();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int done_cyc, ncnt, nsp, ninv1, ninv2, ndone, last_done, gap;
      #3;
      check_all();
      #4 rst_n = 1'b1;
      step();

      // Directed encrypt block: trace against hand-derived values
      start = 1'b1;
      dec_in = 1'b0;
      step();
      start = 1'b0;
      chk("accept_dec", int'(Dec_EncBar), 0);
      done_cyc = 0; ncnt = 0; nsp = 0; ninv1 = 0; ninv2 = 0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         if (c > 1) step();
         if (done) done_cyc = c;
         else begin
            ncnt += int'(cnt_en);
            nsp += int'(start_path);
            ninv1 += int'(inv1_ctrl);
            ninv2 += int'(inv2_ctrl);
         end
         if (c == 2) chk("sp_c2", int'(start_path), 1);
         if (c == 3) chk("sp_c3", int'(start_path), 0);
         if (c == 12) chk("inv1_c12", int'(inv1_ctrl), 0);
         if (c == 13) chk("inv1_c13", int'(inv1_ctrl), 1);
         if (c == 22) chk("cnten_c22", int'(cnt_en), 1);
         if (c == 24) chk("cnten_c24", int'(cnt_en), 0);
      end
      chk("done_latency", done_cyc, 25);
      chk("cnt_en_count", ncnt, 11);
      chk("start_path_count", nsp, 2);
      chk("inv2_count", ninv2, 10);
      chk("inv1_count", ninv1, 12);
      step();
      chk("idle_after_done", int'(ready), 1);

      // Decrypt with a start pulse and mode change during busy
      start = 1'b1;
      dec_in = 1'b1;
      step();
      start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 5) begin
            start = 1'b1;
            dec_in = 1'b0;
         end
         if (c == 6) start = 1'b0;
         step();
         ndone += int'(done);
      end
      chk("single_done", ndone, 1);
      chk("dec_held", int'(Dec_EncBar), 1);

      // Reset during pass 6
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 13; c++) step();
      async_reset();
      chk("rst_ready", int'(ready), 1);
      ndone = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         ndone += int'(done);
      end
      chk("no_done_after_rst", ndone, 0);

      // Start held: back-to-back throughput
      start = 1'b1;
      last_done = -1;
      gap = 0;
      for (int c = 0; c < 4 * TOT; c++) begin
         step();
         if (done) begin
            if (last_done >= 0) gap = c - last_done;
            last_done = c;
         end
      end
      start = 1'b0;
      chk("b2b_period", gap, 26);

      // Random stimulus
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         dec_in = 1'($urandom);
`ifdef PRINCE_ABORT_EN
         ab = ($urandom_range(0, 60) == 0);
`endif
         step();
         if ($urandom_range(0, 250) == 0) async_reset();
      end
      ab = 1'b0;
      start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
